div_sequencer: RTL

Multi-cycle signed integer divide controller for the Mini SRC ALU datapath. It accepts a dividend/divisor pair on a start pulse and runs non-restoring division one iteration per clock. It applies sign correction and drives the 64-bit {remainder, quotient} result that the datapath loads into HI/LO. It replaces the single-cycle combinational divide in the critical path and gives the control unit a busy/done handshake.

---
 rtl/div_sequencer_if.sv | 22 ++
 rtl/div_sequencer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/div_sequencer_if.sv
// Handshake and operand/result bundle between the control unit and the divide sequencer.
interface div_sequencer_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 busy;
    logic                 done;
    logic                 dz;
    logic [2*WIDTH-1:0]   Z;

    modport master (
        output start, A, B,
        input  busy, done, dz, Z
    );

    modport slave (
        input  start, A, B,
        output busy, done, dz, Z
    );
endinterface

// File: rtl/div_sequencer.sv
// Multi-cycle signed non-restoring divider; Z = {remainder, quotient}.
// Sign correction is applied in FIX.
module div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic           clock,
    input  logic           clear,
    div_sequencer_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_cap;
    logic [WIDTH-1:0]   b_cap;
    logic [WIDTH-1:0]   qreg;
    logic [WIDTH:0]     mreg;
    logic [WIDTH:0]     p;
    logic [CW-1:0]      count;
    logic               sign_q;
    logic               sign_r;
    logic               zdiv;
    logic               busy_r;
    logic               done_r;
    logic               dz_r;
    logic [2*WIDTH-1:0] z_r;

    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH:0]     p_sh;
    logic [WIDTH:0]     p_step;
    logic [WIDTH:0]     p_fix;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    always_comb begin
        a_abs  = a_cap[WIDTH-1] ? -a_cap : a_cap;
        b_abs  = b_cap[WIDTH-1] ? -b_cap : b_cap;
        p_sh   = {p[WIDTH-1:0], qreg[WIDTH-1]};
        p_step = p[WIDTH] ? (p_sh + mreg) : (p_sh - mreg);
        p_fix  = p[WIDTH] ? (p + mreg) : p;
        quo    = sign_q ? -qreg : qreg;
        rem    = sign_r ? -p_fix[WIDTH-1:0] : p_fix[WIDTH-1:0];
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state  <= IDLE;
            a_cap  <= '0;
            b_cap  <= '0;
            qreg   <= '0;
            mreg   <= '0;
            p      <= '0;
            count  <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            zdiv   <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            dz_r   <= 1'b0;
            z_r    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_cap  <= bus.A;
                        b_cap  <= bus.B;
                        busy_r <= 1'b1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    // Divide-by-zero takes one extra cycle through FIX so done lands at E0+2.
                    if (b_cap == '0) begin
                        zdiv  <= 1'b1;
                        state <= FIX;
                    end else begin
                        zdiv   <= 1'b0;
                        qreg   <= a_abs;
                        mreg   <= {1'b0, b_abs};
                        p      <= '0;
                        count  <= '0;
                        sign_q <= a_cap[WIDTH-1] ^ b_cap[WIDTH-1];
                        sign_r <= a_cap[WIDTH-1];
                        state  <= ITER;
                    end
                end
                ITER: begin
                    p     <= p_step;
                    qreg  <= {qreg[WIDTH-2:0], ~p_step[WIDTH]};
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (zdiv) begin
                        z_r  <= {a_cap, {WIDTH{1'b1}}};
                        dz_r <= 1'b1;
                    end else begin
                        p    <= p_fix;
                        z_r  <= {rem, quo};
                        dz_r <= 1'b0;
                    end
                    done_r <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.dz   = dz_r;
    assign bus.Z    = z_r;
endmodule
